keep_stream_downsizer: RTL and testbench



---
 rtl/keep_stream_downsizer_pkg.sv | 28 ++
 rtl/keep_stream_downsizer_lsb_priority_encoder.sv | 21 ++
 rtl/keep_stream_downsizer.sv | 131 +++++++++++++
 tb/tb_keep_stream_downsizer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keep_stream_downsizer_pkg.sv
// Shared types and mask helpers for the keep-stream downsizer.
// Mask helpers work on a fixed maximum width; callers zero-extend narrower masks.
package stream_pkg;

    localparam int MAX_RATIO = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic logic [4:0] lowest_set_idx(input logic [MAX_RATIO-1:0] mask);
        logic [4:0] idx;
        idx = '0;
        for (int i = MAX_RATIO - 1; i >= 0; i--) begin
            if (mask[i]) idx = i[4:0];
        end
        return idx;
    endfunction

    // True when at most one bit of the mask is set.
    function automatic logic one_hot_or_zero(input logic [MAX_RATIO-1:0] mask);
        logic [MAX_RATIO-1:0] one;
        one = {{(MAX_RATIO-1){1'b0}}, 1'b1};
        return (mask & (mask - one)) == '0;
    endfunction

endpackage

// File: rtl/keep_stream_downsizer_lsb_priority_encoder.sv
// Combinational lowest-set-bit encoder: index of the lowest 1 in mask, valid when any bit set.
module lsb_priority_encoder #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0]         mask,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     valid
);

    localparam int IDX_W = $clog2(WIDTH);

    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mask[i]) idx = i[IDX_W-1:0];
        end
    end

    assign valid = |mask;

endmodule

// File: rtl/keep_stream_downsizer.sv
// Serializes one wide keep-FIFO beat into narrow AXI-Stream beats, lowest kept sub-word first.
// Valid/ready: a transfer happens on either side exactly in a cycle where valid & ready are both 1.
module keep_stream_downsizer
    import stream_pkg::*;
#(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_DATA_RATIO = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [T_DATA_WIDTH*T_DATA_RATIO-1:0] s_data_i,
    input  logic [T_DATA_RATIO-1:0]              s_keep_i,
    input  logic                                 s_last_i,
    input  logic                                 s_valid_i,
    output logic                                 s_ready_o,
    output logic [T_DATA_WIDTH-1:0]              m_data_o,
    output logic                                 m_keep_o,
    output logic                                 m_last_o,
    output logic                                 m_valid_o,
    input  logic                                 m_ready_i,
    output state_t                               dbg_state
);

    localparam int IDX_W  = $clog2(T_DATA_RATIO);
    localparam int WIDE_W = T_DATA_WIDTH * T_DATA_RATIO;

    state_t                   state_q;
    logic [WIDE_W-1:0]        data_q;
    logic [T_DATA_RATIO-1:0]  rem_q;
    logic                     last_q;
    logic                     null_q;

    logic                     final_beat;
    logic                     accept;
    logic                     fire;
    logic [T_DATA_RATIO-1:0]  rem_adv;
    logic [T_DATA_RATIO-1:0]  nxt_mask;
    logic [WIDE_W-1:0]        nxt_data;
    logic                     nxt_one;
    logic [IDX_W-1:0]         sel_idx;
    logic                     sel_valid;
    logic [T_DATA_WIDTH-1:0]  words [T_DATA_RATIO];
    logic [T_DATA_WIDTH-1:0]  sub_word;

    assign final_beat = null_q | ((rem_q != '0) & one_hot_or_zero(MAX_RATIO'(rem_q)));

    // Ready looks through to m_ready_i so a new beat can load as the last narrow beat leaves.
    assign s_ready_o = rst_n & ((state_q == IDLE) |
                                ((state_q == SEND) & m_ready_i & final_beat));

    assign accept = s_valid_i & s_ready_o;
    assign fire   = m_valid_o & m_ready_i;

    // Clearing the lowest set bit is the same as clearing bit idx of the current beat.
    assign rem_adv  = rem_q & (rem_q - T_DATA_RATIO'(1));
    assign nxt_mask = accept ? s_keep_i : rem_adv;
    assign nxt_data = accept ? s_data_i : data_q;
    assign nxt_one  = one_hot_or_zero(MAX_RATIO'(nxt_mask));

    lsb_priority_encoder #(
        .WIDTH (T_DATA_RATIO)
    ) u_enc (
        .mask  (nxt_mask),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

    for (genvar k = 0; k < T_DATA_RATIO; k++) begin : g_words
        assign words[k] = nxt_data[k*T_DATA_WIDTH +: T_DATA_WIDTH];
    end

    assign sub_word  = words[sel_idx];
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            data_q    <= '0;
            rem_q     <= '0;
            last_q    <= 1'b0;
            null_q    <= 1'b0;
            m_valid_o <= 1'b0;
            m_data_o  <= '0;
            m_keep_o  <= 1'b0;
            m_last_o  <= 1'b0;
        end else if (accept) begin
            data_q <= s_data_i;
            rem_q  <= s_keep_i;
            last_q <= s_last_i;
            if (s_keep_i != '0) begin
                state_q   <= SEND;
                null_q    <= 1'b0;
                m_valid_o <= 1'b1;
                m_data_o  <= sub_word;
                m_keep_o  <= sel_valid;
                m_last_o  <= s_last_i & nxt_one;
            end else if (s_last_i) begin
                // Empty final beat still has to close the packet downstream.
                state_q   <= SEND;
                null_q    <= 1'b1;
                m_valid_o <= 1'b1;
                m_data_o  <= '0;
                m_keep_o  <= 1'b0;
                m_last_o  <= 1'b1;
            end else begin
                state_q   <= IDLE;
                null_q    <= 1'b0;
                m_valid_o <= 1'b0;
                m_data_o  <= '0;
                m_keep_o  <= 1'b0;
                m_last_o  <= 1'b0;
            end
        end else if (fire) begin
            if (final_beat) begin
                state_q   <= IDLE;
                rem_q     <= '0;
                null_q    <= 1'b0;
                m_valid_o <= 1'b0;
                m_data_o  <= '0;
                m_keep_o  <= 1'b0;
                m_last_o  <= 1'b0;
            end else begin
                rem_q    <= rem_adv;
                m_data_o <= sub_word;
                m_keep_o <= sel_valid;
                m_last_o <= last_q & nxt_one;
            end
        end
    end

endmodule

// File: tb/tb_keep_stream_downsizer.sv
// Directed bench for keep_stream_downsizer: ratio-2 and ratio-4 instances, expected-beat queues.
module tb_keep_stream_downsizer;
    import stream_pkg::*;

    logic clk;
    logic rst_n;

    logic [15:0] s_data2;
    logic [1:0]  s_keep2;
    logic        s_last2, s_valid2, s_ready2;
    logic [7:0]  m_data2;
    logic        m_keep2, m_last2, m_valid2, m_ready2;
    state_t      st2;

    logic [31:0] s_data4;
    logic [3:0]  s_keep4;
    logic        s_last4, s_valid4, s_ready4;
    logic [7:0]  m_data4;
    logic        m_keep4, m_last4, m_valid4, m_ready4;
    state_t      st4;

    logic [9:0] exp2_q[$];
    logic [9:0] exp4_q[$];
    int         fire_cyc2[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         fire2_cnt = 0;
    int         saved_cnt;

    keep_stream_downsizer #(.T_DATA_WIDTH(8), .T_DATA_RATIO(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .s_data_i(s_data2), .s_keep_i(s_keep2), .s_last_i(s_last2),
        .s_valid_i(s_valid2), .s_ready_o(s_ready2),
        .m_data_o(m_data2), .m_keep_o(m_keep2), .m_last_o(m_last2),
        .m_valid_o(m_valid2), .m_ready_i(m_ready2), .dbg_state(st2)
    );

    keep_stream_downsizer #(.T_DATA_WIDTH(8), .T_DATA_RATIO(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .s_data_i(s_data4), .s_keep_i(s_keep4), .s_last_i(s_last4),
        .s_valid_i(s_valid4), .s_ready_o(s_ready4),
        .m_data_o(m_data4), .m_keep_o(m_keep4), .m_last_o(m_last4),
        .m_valid_o(m_valid4), .m_ready_i(m_ready4), .dbg_state(st4)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every narrow handshake pops one expected {keep, last, data}
    always @(negedge clk) begin
        logic [9:0] e;
        cyc++;
        if (rst_n && m_valid2 && m_ready2) begin
            if (exp2_q.size() == 0) check("unexpected beat2", 32'd1, 32'd0);
            else begin
                e = exp2_q.pop_front();
                check("beat2", {22'd0, m_keep2, m_last2, m_data2}, {22'd0, e});
            end
            fire2_cnt++;
            fire_cyc2.push_back(cyc);
        end
        if (rst_n && m_valid4 && m_ready4) begin
            if (exp4_q.size() == 0) check("unexpected beat4", 32'd1, 32'd0);
            else begin
                e = exp4_q.pop_front();
                check("beat4", {22'd0, m_keep4, m_last4, m_data4}, {22'd0, e});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drivers: called just after a posedge; return just after the accepting posedge
    task automatic send2(input logic [15:0] d, input logic [1:0] k, input logic l);
        int n;
        n = 0;
        s_data2 = d; s_keep2 = k; s_last2 = l; s_valid2 = 1'b1;
        @(negedge clk);
        while (!s_ready2 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("accept2", {31'd0, s_ready2}, 32'd1);
        step();
        s_valid2 = 1'b0;
    endtask

    task automatic send4(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        n = 0;
        s_data4 = d; s_keep4 = k; s_last4 = l; s_valid4 = 1'b1;
        @(negedge clk);
        while (!s_ready4 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("accept4", {31'd0, s_ready4}, 32'd1);
        step();
        s_valid4 = 1'b0;
    endtask

    task automatic drain(input int which);
        int n;
        n = 0;
        while (((which == 2) ? exp2_q.size() : exp4_q.size()) != 0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check((which == 2) ? "drain2" : "drain4",
              (which == 2) ? exp2_q.size() : exp4_q.size(), 32'd0);
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        s_data2 = '0; s_keep2 = '0; s_last2 = 1'b0; s_valid2 = 1'b0; m_ready2 = 1'b1;
        s_data4 = '0; s_keep4 = '0; s_last4 = 1'b0; s_valid4 = 1'b0; m_ready4 = 1'b1;

        // Reset state
        #3;
        check("rst m_valid", {31'd0, m_valid2}, 32'd0);
        check("rst s_ready", {31'd0, s_ready2}, 32'd0);
        check("rst m_data", {24'd0, m_data2}, 32'd0);
        check("rst m_keep", {31'd0, m_keep2}, 32'd0);
        check("rst m_last", {31'd0, m_last2}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post-rst s_ready", {31'd0, s_ready2}, 32'd1);
        check("post-rst state", {31'd0, st2}, {31'd0, IDLE});
        check("post-rst s_ready4", {31'd0, s_ready4}, 32'd1);
        step();

        // Full keep: AA then BB, ready back during BB
        exp2_q.push_back({1'b1, 1'b0, 8'hAA});
        exp2_q.push_back({1'b1, 1'b1, 8'hBB});
        s_data2 = 16'hBBAA; s_keep2 = 2'b11; s_last2 = 1'b1; s_valid2 = 1'b1;
        @(negedge clk);
        check("t1 idle ready", {31'd0, s_ready2}, 32'd1);
        step();
        s_valid2 = 1'b0;
        @(negedge clk);
        check("t1 AA data", {24'd0, m_data2}, 32'hAA);
        check("t1 AA last", {31'd0, m_last2}, 32'd0);
        check("t1 AA s_ready", {31'd0, s_ready2}, 32'd0);
        @(negedge clk);
        check("t1 BB data", {24'd0, m_data2}, 32'hBB);
        check("t1 BB last", {31'd0, m_last2}, 32'd1);
        check("t1 BB s_ready", {31'd0, s_ready2}, 32'd1);
        @(negedge clk);
        check("t1 done valid", {31'd0, m_valid2}, 32'd0);
        step();
        drain(2);

        // Ratio 4, sparse keep 1010: 22 then 44
        exp4_q.push_back({1'b1, 1'b0, 8'h22});
        exp4_q.push_back({1'b1, 1'b0, 8'h44});
        send4(32'h44332211, 4'b1010, 1'b0);
        @(negedge clk);
        check("t2 first", {24'd0, m_data4}, 32'h22);
        @(negedge clk);
        check("t2 second", {24'd0, m_data4}, 32'h44);
        @(negedge clk);
        check("t2 done valid", {31'd0, m_valid4}, 32'd0);
        step();
        drain(4);

        // Dropped empty beat, then single CC
        send2(16'h1234, 2'b00, 1'b0);
        @(negedge clk);
        check("t3 drop valid", {31'd0, m_valid2}, 32'd0);
        check("t3 drop state", {31'd0, st2}, {31'd0, IDLE});
        step();
        exp2_q.push_back({1'b1, 1'b1, 8'hCC});
        send2(16'h00CC, 2'b01, 1'b1);
        @(negedge clk);
        check("t3 CC data", {24'd0, m_data2}, 32'hCC);
        check("t3 CC last", {31'd0, m_last2}, 32'd1);
        step();
        drain(2);

        // Null last beat
        exp2_q.push_back({1'b0, 1'b1, 8'h00});
        send2(16'h5A5A, 2'b00, 1'b1);
        @(negedge clk);
        check("t4 null valid", {31'd0, m_valid2}, 32'd1);
        check("t4 null keep", {31'd0, m_keep2}, 32'd0);
        check("t4 null last", {31'd0, m_last2}, 32'd1);
        check("t4 null data", {24'd0, m_data2}, 32'd0);
        step();
        drain(2);

        // Back-pressure holds AA
        m_ready2 = 1'b0;
        exp2_q.push_back({1'b1, 1'b0, 8'hAA});
        exp2_q.push_back({1'b1, 1'b1, 8'hBB});
        send2(16'hBBAA, 2'b11, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5 hold data", {24'd0, m_data2}, 32'hAA);
            check("t5 hold valid", {31'd0, m_valid2}, 32'd1);
            check("t5 hold s_ready", {31'd0, s_ready2}, 32'd0);
        end
        step();
        m_ready2 = 1'b1;
        drain(2);

        // Back-to-back wide beats: four narrow beats in four consecutive cycles
        fire_cyc2.delete();
        exp2_q.push_back({1'b1, 1'b0, 8'hAA});
        exp2_q.push_back({1'b1, 1'b0, 8'hBB});
        exp2_q.push_back({1'b1, 1'b0, 8'hCC});
        exp2_q.push_back({1'b1, 1'b1, 8'hDD});
        send2(16'hBBAA, 2'b11, 1'b0);
        send2(16'hDDCC, 2'b11, 1'b1);
        drain(2);
        check("t6 beat count", fire_cyc2.size(), 32'd4);
        if (fire_cyc2.size() == 4)
            check("t6 no bubble", fire_cyc2[3] - fire_cyc2[0], 32'd3);

        // Reset while BB is pending
        m_ready2 = 1'b0;
        exp2_q.push_back({1'b1, 1'b0, 8'hAA});
        send2(16'hBBAA, 2'b11, 1'b1);
        @(negedge clk);
        check("t7 AA data", {24'd0, m_data2}, 32'hAA);
        step();
        m_ready2 = 1'b1;
        @(negedge clk);
        step();
        m_ready2 = 1'b0;
        @(negedge clk);
        check("t7 BB pending", {24'd0, m_data2}, 32'hBB);
        check("t7 BB valid", {31'd0, m_valid2}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t7 rst valid", {31'd0, m_valid2}, 32'd0);
        check("t7 rst s_ready", {31'd0, s_ready2}, 32'd0);
        saved_cnt = fire2_cnt;
        step();
        rst_n = 1'b1;
        m_ready2 = 1'b1;
        @(negedge clk);
        check("t7 rel state", {31'd0, st2}, {31'd0, IDLE});
        check("t7 rel s_ready", {31'd0, s_ready2}, 32'd1);
        check("t7 rel valid", {31'd0, m_valid2}, 32'd0);
        repeat (4) @(negedge clk);
        check("t7 no stale beat", fire2_cnt, saved_cnt);
        check("t7 queue", exp2_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
